// File: rtl/pipe_if.sv
// Game-state input and pipe/score outputs between the game FSM and pipe_ctrl.
interface pipe_if;
  logic [1:0]  state;
  logic [9:0]  pip1_X;
  logic [8:0]  pip1_Y;
  logic [9:0]  pip2_X;
  logic [8:0]  pip2_Y;
  logic [11:0] score_bcd;
  logic [11:0] best_bcd;
  logic        score_pulse;

  modport master (
    output state,
    input  pip1_X, pip1_Y, pip2_X, pip2_Y, score_bcd, best_bcd, score_pulse
  );
  modport slave (
    input  state,
    output pip1_X, pip1_Y, pip2_X, pip2_Y, score_bcd, best_bcd, score_pulse
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Scrolling pipe pair with LFSR gap heights and BCD score/best tracking.
module pipe_lane #(
  parameter int X_RST   = 700,
  parameter int SPACING = 320,
  parameter int SPEED   = 2,
  parameter int Y_MIN   = 240
) (
  input  logic       clk_ms,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic [6:0] rnd_rdy,
  input  logic [6:0] rnd_play,
  output logic [9:0] x,
  output logic [9:0] x_nxt,
  output logic [8:0] y
);
  localparam logic [9:0] XR  = 10'(X_RST);
  localparam logic [9:0] SPD = 10'(SPEED);
  localparam logic [9:0] RCY = 10'(2*SPACING - SPEED);
  localparam logic [8:0] YM  = 9'(Y_MIN);

  logic [8:0] y_nxt;

  // Recycling adds two spacings minus the step so the pair stays exactly SPACING apart.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    case (state)
      2'd0: begin
        x_nxt = XR;
        y_nxt = YM + {2'b00, rnd_rdy};
      end
      2'd1: begin
        if (x < SPD) begin
          x_nxt = x + RCY;
          y_nxt = YM + {2'b00, rnd_play};
        end else begin
          x_nxt = x - SPD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      x <= XR;
      y <= YM;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end
endmodule

module pipe_ctrl #(
  parameter int          INIT_X    = 700,
  parameter int          SPACING   = 320,
  parameter int          SPEED     = 2,
  parameter int          BIRD_LEFT = 286,
  parameter int          Y_MIN     = 240,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic  clk_ms,
  input logic  rst_n,
  pipe_if.slave bus
);
  localparam int         NUM_PIPES = 2;
  localparam logic [9:0] BL        = 10'(BIRD_LEFT);

  logic [NUM_PIPES-1:0][9:0] x, x_nxt;
  logic [NUM_PIPES-1:0][8:0] y;
  logic [15:0] lfsr;
  logic        front;
  logic [11:0] score, best;
  logic        pulse;
  logic [1:0]  prev_state;
  logic        score_hit;

  for (genvar k = 0; k < NUM_PIPES; k++) begin : g_pipe
    pipe_lane #(
      .X_RST  (INIT_X + k*SPACING),
      .SPACING(SPACING),
      .SPEED  (SPEED),
      .Y_MIN  (Y_MIN)
    ) u_lane (
      .clk_ms  (clk_ms),
      .rst_n   (rst_n),
      .state   (bus.state),
      .rnd_rdy ((k == 0) ? lfsr[6:0] : lfsr[14:8]),
      .rnd_play(lfsr[6:0]),
      .x       (x[k]),
      .x_nxt   (x_nxt[k]),
      .y       (y[k])
    );
  end

  function automatic logic [11:0] bcd_inc(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    if (s != 12'h999) begin
      if (s[3:0] != 4'd9) r[3:0] = s[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (s[7:4] != 4'd9) r[7:4] = s[7:4] + 4'd1;
        else begin
          r[7:4]  = 4'd0;
          r[11:8] = s[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign score_hit = (bus.state == 2'd1) && (x[front] >= BL) && (x_nxt[front] < BL);

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      front      <= 1'b0;
      score      <= 12'h000;
      best       <= 12'h000;
      pulse      <= 1'b0;
      prev_state <= 2'd0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      prev_state <= bus.state;
      pulse      <= 1'b0;
      if (bus.state == 2'd0) begin
        front <= 1'b0;
        score <= 12'h000;
      end else if (score_hit) begin
        score <= bcd_inc(score);
        front <= ~front;
        pulse <= 1'b1;
      end
      // Packed BCD compares correctly as plain binary.
      if (prev_state == 2'd1 && bus.state != 2'd1 && score > best)
        best <= score;
    end
  end

  assign bus.pip1_X      = x[front];
  assign bus.pip1_Y      = y[front];
  assign bus.pip2_X      = x[~front];
  assign bus.pip2_Y      = y[~front];
  assign bus.score_bcd   = score;
  assign bus.best_bcd    = best;
  assign bus.score_pulse = pulse;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven scoreboard bench: a nominal pipe_ctrl plus a fast-scrolling one for BCD wrap/saturation.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_if m_if ();
  pipe_if f_if ();

  pipe_ctrl dut (.clk_ms(clk), .rst_n(rst_n), .bus(m_if.slave));
  // SPEED=160: pipes pass the bird every 2 ticks, so score n lands on play tick 2n+1.
  pipe_ctrl #(.SPEED(160)) dut_f (.clk_ms(clk), .rst_n(rst_n), .bus(f_if.slave));

  typedef struct {
    string    name;
    bit       fast;
    bit [1:0] st;
    int       ticks;
    bit       chk_x;
    int       x1, x2;
    int       ymode;  // 0 none, 1 both 240, 2 ready capture, 3 pip2_Y = last recycle draw
    int       sc, bs;
    bit       pl;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0, failures = 0;
  int   rdy_lo, rdy_hi, rec_lo;

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick(input bit fast, input logic [1:0] st);
    if (fast) f_if.state = st;
    else begin
      m_if.state = st;
      if (st == 2'd0) begin
        rdy_lo = 240 + int'(m_lfsr[6:0]);
        rdy_hi = 240 + int'(m_lfsr[14:8]);
      end
      rec_lo = 240 + int'(m_lfsr[6:0]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t v, e;
    int ax1, ax2, ay1, ay2, asc, abs, apl;

    //            name        fast st  ticks chkx x1   x2    ym sc      bs      pl
    tbl.push_back('{"reset",     0, 0,    0, 1, 700, 1020, 1, 'h000, 'h000, 0});
    tbl.push_back('{"ready5",    0, 0,    5, 1, 700, 1020, 2, 'h000, 'h000, 0});
    tbl.push_back('{"play1",     0, 1,    1, 1, 698, 1018, 2, 'h000, 'h000, 0});
    tbl.push_back('{"play207",   0, 1,  206, 1, 286,  606, 0, 'h000, 'h000, 0});
    tbl.push_back('{"score1",    0, 1,    1, 1, 604,  284, 0, 'h001, 'h000, 1});
    tbl.push_back('{"pulse_off", 0, 1,    1, 1, 602,  282, 0, 'h001, 'h000, 0});
    tbl.push_back('{"pre_recyc", 0, 1,  141, 1, 320,    0, 0, 'h001, 'h000, 0});
    tbl.push_back('{"recycle",   0, 1,    1, 1, 318,  638, 3, 'h001, 'h000, 0});
    tbl.push_back('{"score5",    0, 1,  497, 1, 604,  284, 0, 'h005, 'h000, 1});
    tbl.push_back('{"die",       0, 2,    1, 1, 604,  284, 0, 'h005, 'h005, 0});
    tbl.push_back('{"hold50",    0, 2,   49, 1, 604,  284, 0, 'h005, 'h005, 0});
    tbl.push_back('{"ready_clr", 0, 0,    1, 1, 700, 1020, 2, 'h000, 'h005, 0});
    tbl.push_back('{"play528",   0, 1,  528, 1, 604,  284, 0, 'h003, 'h005, 1});
    tbl.push_back('{"die2",      0, 2,    1, 1, 604,  284, 0, 'h003, 'h005, 0});
    tbl.push_back('{"f_s9",      1, 1,   19, 0,   0,    0, 0, 'h009, 'h000, 1});
    tbl.push_back('{"f_s10",     1, 1,    2, 0,   0,    0, 0, 'h010, 'h000, 1});
    tbl.push_back('{"f_s99",     1, 1,  178, 0,   0,    0, 0, 'h099, 'h000, 1});
    tbl.push_back('{"f_s100",    1, 1,    2, 0,   0,    0, 0, 'h100, 'h000, 1});
    tbl.push_back('{"f_s999",    1, 1, 1798, 0,   0,    0, 0, 'h999, 'h000, 1});
    tbl.push_back('{"f_gap",     1, 1,    1, 0,   0,    0, 0, 'h999, 'h000, 0});
    tbl.push_back('{"f_sat",     1, 1,    1, 0,   0,    0, 0, 'h999, 'h000, 1});
    tbl.push_back('{"f_best",    1, 2,    1, 0,   0,    0, 0, 'h999, 'h999, 0});
    tbl.push_back('{"resume",    0, 1,   10, 1, 584,  264, 0, 'h003, 'h005, 0});

    rst_n = 1'b0;
    m_if.state = 2'd0;
    f_if.state = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      sb.push_back(v);
      repeat (v.ticks) tick(v.fast, v.st);
      e = sb.pop_front();
      if (e.fast) begin
        ax1 = int'(f_if.pip1_X); ax2 = int'(f_if.pip2_X);
        ay1 = int'(f_if.pip1_Y); ay2 = int'(f_if.pip2_Y);
        asc = int'(f_if.score_bcd); abs = int'(f_if.best_bcd); apl = int'(f_if.score_pulse);
      end else begin
        ax1 = int'(m_if.pip1_X); ax2 = int'(m_if.pip2_X);
        ay1 = int'(m_if.pip1_Y); ay2 = int'(m_if.pip2_Y);
        asc = int'(m_if.score_bcd); abs = int'(m_if.best_bcd); apl = int'(m_if.score_pulse);
      end
      if (e.chk_x) begin
        chk({e.name, ".pip1_X"}, ax1, e.x1);
        chk({e.name, ".pip2_X"}, ax2, e.x2);
      end
      case (e.ymode)
        1: begin chk({e.name, ".pip1_Y"}, ay1, 240);    chk({e.name, ".pip2_Y"}, ay2, 240); end
        2: begin chk({e.name, ".pip1_Y"}, ay1, rdy_lo); chk({e.name, ".pip2_Y"}, ay2, rdy_hi); end
        3: chk({e.name, ".pip2_Y"}, ay2, rec_lo);
        default: ;
      endcase
      chk({e.name, ".score"}, asc, e.sc);
      chk({e.name, ".best"},  abs, e.bs);
      chk({e.name, ".pulse"}, apl, int'(e.pl));
    end

    // Asynchronous reset mid-play, sampled before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("arst.pip1_X", int'(m_if.pip1_X), 700);
    chk("arst.pip2_X", int'(m_if.pip2_X), 1020);
    chk("arst.pip1_Y", int'(m_if.pip1_Y), 240);
    chk("arst.pip2_Y", int'(m_if.pip2_Y), 240);
    chk("arst.score",  int'(m_if.score_bcd), 0);
    chk("arst.best",   int'(m_if.best_bcd), 0);
    chk("arst.pulse",  int'(m_if.score_pulse), 0);
    chk("arst.f_best", int'(f_if.best_bcd), 0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
